// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Brief    : Prescaled LED pattern sequencer (rotate right/left, bounce, hold)
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             dir
);

    localparam logic [1:0]       c_MODE_ROR    = 2'b00;
    localparam logic [1:0]       c_MODE_ROL    = 2'b01;
    localparam logic [1:0]       c_MODE_BOUNCE = 2'b10;
    localparam logic [WIDTH-1:0] c_LED_MSB     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DIV_W-1:0] c_CNT_ONE     = 1;

    logic [DIV_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_led;
    logic             r_step;
    logic             r_dir;

    logic             w_adv;
    logic [WIDTH-1:0] w_led_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_load_pat;

    assign w_adv      = en && !load && (r_cnt == div);
    assign w_load_pat = (load_val == '0) ? c_LED_MSB : load_val;

    // Pattern produced by the next advance; the bounce reverses at whichever
    // end is lit and shifts away from it in the same step.
    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        case (mode)
            c_MODE_ROR: w_led_nxt = {r_led[0], r_led[WIDTH-1:1]};
            c_MODE_ROL: w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            c_MODE_BOUNCE: begin
                if (r_led[0] && r_led[WIDTH-1]) begin
                    w_dir_nxt = ~r_dir;
                end else if (!r_dir) begin
                    if (r_led[0]) begin
                        w_dir_nxt = 1'b1;
                        w_led_nxt = r_led << 1;
                    end else begin
                        w_led_nxt = r_led >> 1;
                    end
                end else begin
                    if (r_led[WIDTH-1]) begin
                        w_dir_nxt = 1'b0;
                        w_led_nxt = r_led >> 1;
                    end else begin
                        w_led_nxt = r_led << 1;
                    end
                end
            end
            default: w_led_nxt = r_led;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_led  <= c_LED_MSB;
            r_step <= 1'b0;
            r_dir  <= 1'b0;
        end else if (load) begin
            r_cnt  <= '0;
            r_led  <= w_load_pat;
            r_step <= 1'b0;
            r_dir  <= 1'b0;
        end else begin
            r_step <= w_adv;
            if (en) begin
                r_cnt <= (r_cnt == div) ? '0 : r_cnt + c_CNT_ONE;
            end
            if (w_adv) begin
                r_led <= w_led_nxt;
                r_dir <= w_dir_nxt;
            end
        end
    end

    assign led  = r_led;
    assign step = r_step;
    assign dir  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Brief    : Directed vector bench for led_pattern_gen (WIDTH=4 and WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance with a narrow prescaler so wrap-around is reachable
    logic       reset4 = 1'b1;
    logic       en4 = 1'b0;
    logic [1:0] mode4 = 2'b00;
    logic [2:0] div4 = 3'd0;
    logic       load4 = 1'b0;
    logic [3:0] load_val4 = 4'd0;
    logic [3:0] led4;
    logic       step4;
    logic       dir4;

    logic        reset8 = 1'b1;
    logic        en8 = 1'b0;
    logic [1:0]  mode8 = 2'b00;
    logic [23:0] div8 = 24'd0;
    logic        load8 = 1'b0;
    logic [7:0]  load_val8 = 8'd0;
    logic [7:0]  led8;
    logic        step8;
    logic        dir8;

    led_pattern_gen #(.WIDTH(4), .DIV_W(3)) u_dut4 (
        .clk(clk), .reset(reset4), .en(en4), .mode(mode4), .div(div4),
        .load(load4), .load_val(load_val4), .led(led4), .step(step4), .dir(dir4)
    );

    led_pattern_gen #(.WIDTH(8), .DIV_W(24)) u_dut8 (
        .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .div(div8),
        .load(load8), .load_val(load_val8), .led(led8), .step(step8), .dir(dir8)
    );

    typedef struct {
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic [1:0] mode;
        logic [2:0] div;
        logic [3:0] exp_led;
        logic       exp_step;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    logic [7:0] exp_led8 [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic       exp_dir8 [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [3:0] lv, input logic e,
                       input logic [1:0] m, input logic [2:0] d,
                       input logic [3:0] l, input logic s, input logic dr);
        vec_t v;
        v.load = ld; v.load_val = lv; v.en = e; v.mode = m; v.div = d;
        v.exp_led = l; v.exp_step = s; v.exp_dir = dr;
        vecs.push_back(v);
    endtask

    initial begin
        // Rotate right, div=0: advance every cycle
        add(0, 4'h0, 1, 2'b00, 3'd0, 4'b0100, 1, 0);
        add(0, 4'h0, 1, 2'b00, 3'd0, 4'b0010, 1, 0);
        add(0, 4'h0, 1, 2'b00, 3'd0, 4'b0001, 1, 0);
        add(0, 4'h0, 1, 2'b00, 3'd0, 4'b1000, 1, 0);
        // Rotate left, div=2, with an en=0 freeze in the middle
        repeat (2) add(0, 4'h0, 1, 2'b01, 3'd2, 4'b1000, 0, 0);
        add(0, 4'h0, 1, 2'b01, 3'd2, 4'b0001, 1, 0);
        repeat (5) add(0, 4'h0, 0, 2'b01, 3'd2, 4'b0001, 0, 0);
        repeat (2) add(0, 4'h0, 1, 2'b01, 3'd2, 4'b0001, 0, 0);
        add(0, 4'h0, 1, 2'b01, 3'd2, 4'b0010, 1, 0);
        // Hold mode still pulses step; mode change alone does nothing
        add(0, 4'h0, 1, 2'b11, 3'd0, 4'b0010, 1, 0);
        add(0, 4'h0, 0, 2'b00, 3'd0, 4'b0010, 0, 0);
        // Bounce with both ends lit toggles dir only
        add(1, 4'h9, 1, 2'b10, 3'd0, 4'b1001, 0, 0);
        add(0, 4'h0, 1, 2'b10, 3'd0, 4'b1001, 1, 1);
        add(0, 4'h0, 1, 2'b10, 3'd0, 4'b1001, 1, 0);
        add(0, 4'h0, 1, 2'b10, 3'd0, 4'b1001, 1, 1);
        // dir holds through rotate modes
        add(0, 4'h0, 1, 2'b00, 3'd0, 4'b1100, 1, 1);
        add(0, 4'h0, 1, 2'b01, 3'd0, 4'b1001, 1, 1);
        // Bring cnt to div, then load zero on the match cycle
        repeat (2) add(0, 4'h0, 1, 2'b11, 3'd2, 4'b1001, 0, 1);
        add(1, 4'h0, 1, 2'b11, 3'd2, 4'b1000, 0, 0);
        repeat (2) add(0, 4'h0, 1, 2'b00, 3'd2, 4'b1000, 0, 0);
        add(0, 4'h0, 1, 2'b00, 3'd2, 4'b0100, 1, 0);
        // Lowering div below cnt wraps the 3-bit counter before matching
        repeat (3) add(0, 4'h0, 1, 2'b00, 3'd4, 4'b0100, 0, 0);
        repeat (6) add(0, 4'h0, 1, 2'b00, 3'd1, 4'b0100, 0, 0);
        add(0, 4'h0, 1, 2'b00, 3'd1, 4'b0010, 1, 0);
        // Maximum div: one advance per 8 enabled cycles
        repeat (7) add(0, 4'h0, 1, 2'b00, 3'd7, 4'b0010, 0, 0);
        add(0, 4'h0, 1, 2'b00, 3'd7, 4'b0001, 1, 0);

        // Asynchronous reset values
        #2;
        reset4 = 1'b0;
        reset8 = 1'b0;
        #1;
        check("rst4_led", 32'(led4), 32'h8);
        check("rst4_step", 32'(step4), 32'h0);
        check("rst4_dir", 32'(dir4), 32'h0);
        check("rst8_led", 32'(led8), 32'h80);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset4 = 1'b1;
        reset8 = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            load4 = vecs[i].load; load_val4 = vecs[i].load_val; en4 = vecs[i].en;
            mode4 = vecs[i].mode; div4 = vecs[i].div;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_led", i), 32'(led4), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_step", i), 32'(step4), 32'(vecs[i].exp_step));
            check($sformatf("vec%0d_dir", i), 32'(dir4), 32'(vecs[i].exp_dir));
        end

        // Mid-count asynchronous reset with led=0010, cnt=1
        load4 = 1'b1; load_val4 = 4'b1000; en4 = 1'b1; mode4 = 2'b00; div4 = 3'd2;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_led", 32'(led4), 32'h2);
        #3;
        reset4 = 1'b0;
        #1;
        check("async_rst_led", 32'(led4), 32'h8);
        check("async_rst_step", 32'(step4), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_led", 32'(led4), 32'h8);
        @(negedge clk);
        reset4 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_step", i), 32'(step4), (i == 3) ? 32'h1 : 32'h0);
            check($sformatf("post_rst%0d_led", i), 32'(led4), (i == 3) ? 32'h4 : 32'h8);
        end

        // WIDTH=8 bounce from 01 up to 80 and back
        load8 = 1'b1; load_val8 = 8'h01; en8 = 1'b1; mode8 = 2'b10; div8 = 24'd0;
        @(posedge clk);
        #1;
        check("b8_load_led", 32'(led8), 32'h01);
        check("b8_load_dir", 32'(dir8), 32'h0);
        load8 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b8_step%0d_led", i + 1), 32'(led8), 32'(exp_led8[i]));
            check($sformatf("b8_step%0d_dir", i + 1), 32'(dir8), 32'(exp_dir8[i]));
            check($sformatf("b8_step%0d_pulse", i + 1), 32'(step8), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
